pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
- Second-generation CPU control unit: decodes {op, inst, immin} in ID and carries the control bundle through EX, MEM and WB pipeline registers.
- Adds valid tracking and load-use hazard detection (stall plus bubble).
- Adds taken-branch redirect with flush.
- Sits between the IF/ID instruction register and the datapath stage muxes/enables.

Parameters:
- RA_W, 4, register address width for rd/rs1/rs2.
- ZERO_REG_HAZ, 0: 0 means register 0 never causes a load-use stall; 1 means register 0 compares like any other register.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  IF/ID holds a live instruction
- id_op  in  2  opcode class
- id_inst  in  2  instruction subfield
- id_immin  in  1  immediate/modifier bit
- id_rd  in  RA_W  destination register
- id_rs1  in  RA_W  source register 1
- id_rs2  in  RA_W  source register 2
- ex_cond_true  in  1  EX condition evaluation for the branch in EX
- stall  out  1  hold PC and IF/ID this cycle
- flush  out  1  discard IF/ID contents this cycle
- redirect  out  1  load PC from branch target
- ex_valid  out  1  EX stage valid
- ex_alu_op  out  3  ALU operation
- ex_ext_sel  out  2  immediate extender select
- ex_jmp_f  out  2  branch condition code
- ex_wpc  out  1  EX holds a PC-writing instruction
- mem_valid  out  1  MEM stage valid
- mem_wmem  out  1  data memory write enable
- mem_rmem  out  1  data memory read enable
- wb_valid  out  1  WB stage valid
- wb_wreg  out  1  register file write enable
- wb_rd  out  RA_W  register file write address

Behaviour:
- Decode (combinational, ID):
  - wmem = op==10 & inst==00 & ~immin
  - rmem = op==10 & inst==01 & ~immin
  - wreg = op==11 | (op==10 & inst!=11)
  - wpc = op==00 & immin
  - jmp_f = inst
  - alu_op = {inst,immin} when op==11, else 000 (add)
  - ext_sel: op 00→10, 01→11, 10→01, 11→00
  - op==01 decodes as a NOP: all enables 0.
- Stage capture:
  - Every rising clk edge, EX←ID decode, MEM←EX, WB←MEM.
  - Enables are stored ANDed with the source valid, so a bubble carries all enables 0.
  - Latency from id_valid: EX outputs at +1 cycle, MEM at +2, WB at +3.
- Load-use hazard:
  - load_use = id_valid & ex_valid & ex_rmem & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - When ZERO_REG_HAZ=0, a match on register 0 is ignored.
  - Both sources are compared regardless of opcode (conservative).
- Redirect:
  - redirect = ex_valid & ex_wpc & ex_cond_true, combinational from EX registers.
- Priority (redirect over stall):
  - If redirect: flush=1, stall=0, EX captures a bubble; the EX branch itself advances to MEM normally.
  - Else if load_use: stall=1, flush=0, EX captures a bubble, MEM/WB advance, ID decode is re-presented next cycle.
  - Else: stall=0, flush=0.
- Simultaneous redirect and load_use: redirect wins; the stalled ID instruction is flushed.
- ex_rd is an internal register, captured alongside the EX bundle and forwarded to MEM and WB.
- Reset:
  - All valid bits, enables, alu_op, ext_sel, jmp_f, wb_rd and counters go to 0.
  - stall, flush and redirect are 0 in the cycle after reset.
  - Reset mid-stall or mid-branch discards all in-flight state; there is no pending redirect.
- Back-to-back loads stall at most once per dependent pair: after the bubble, ex_valid=0 for that slot, so load_use deasserts.

Optional Feature:
- Macro: CU_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - Each counter increments on every clk where stall (resp. flush) is 1.
  - Counters saturate at 16'hFFFF (no wrap).
  - Synchronous reset to 0.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- ALU pass-through:
  - Stimulus: id_valid=1, op=11, inst=10, immin=1, rd=5.
  - Response: next cycle ex_valid=1, ex_alu_op=101, ex_ext_sel=00. Two cycles later wb_wreg=1, wb_rd=5. No stall or flush.
- Load-use stall:
  - Stimulus: load (op=10, inst=01, immin=0, rd=3), then op=11 with rs1=3.
  - Response: stall=1 for exactly 1 cycle; EX bubble (ex_valid=0); dependent op reaches EX one cycle later; mem_rmem=1 for the load at cycle +2.
- Zero-register exemption:
  - Stimulus: ZERO_REG_HAZ=0, load rd=0, then dependent rs2=0.
  - Response: stall stays 0.
  - Stimulus: same sequence with ZERO_REG_HAZ=1.
  - Response: stall=1 for 1 cycle.
- Taken branch:
  - Stimulus: op=00, immin=1, inst=10; ex_cond_true=1 in its EX cycle.
  - Response: redirect=1 and flush=1 for 1 cycle; the following instruction never reaches MEM (mem_valid=0 in that slot).
  - Stimulus: same branch with ex_cond_true=0.
  - Response: redirect=0, no flush.
- Redirect vs stall:
  - Stimulus: branch in EX taken while ID holds a load-dependent op.
  - Response: flush=1, stall=0, dependent op discarded.
- Reset mid-flight:
  - Stimulus: assert rst while stall=1 with valid instructions in all stages.
  - Response: next cycle all valids, enables and outputs are 0.
  - Coverage note: with CU_PERF_CNT_EN, reset clears the counters; also force 65536 stalls and check stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// Pipelined control unit: decodes {op, inst, immin} in ID and carries the control bundle through EX/MEM/WB.
// Latency: EX outputs +1 cycle after ID, MEM +2, WB +3; stall/flush/redirect are combinational from EX regs and ID inputs.
// Backpressure: load-use raises stall (IF/ID held, EX bubble); a taken branch raises redirect+flush (ID killed, EX bubble).
// Optional build macro CU_PERF_CNT_EN adds saturating stall_cnt/flush_cnt event counters.
module pipelined_control_unit #(
    parameter int RA_W         = 4,
    parameter int ZERO_REG_HAZ = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [1:0]      id_op,
    input  logic [1:0]      id_inst,
    input  logic            id_immin,
    input  logic [RA_W-1:0] id_rd,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic            ex_cond_true,
    output logic            stall,
    output logic            flush,
    output logic            redirect,
    output logic            ex_valid,
    output logic [2:0]      ex_alu_op,
    output logic [1:0]      ex_ext_sel,
    output logic [1:0]      ex_jmp_f,
    output logic            ex_wpc,
    output logic            mem_valid,
    output logic            mem_wmem,
    output logic            mem_rmem,
    output logic            wb_valid,
    output logic            wb_wreg,
    output logic [RA_W-1:0] wb_rd
`ifdef CU_PERF_CNT_EN
    ,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt
`endif
);

    // ---------------- ID decode results ----------------
    logic            dec_wmem;
    logic            dec_rmem;
    logic            dec_wreg;
    logic            dec_wpc;
    logic [1:0]      dec_jmp_f;
    logic [2:0]      dec_alu_op;
    logic [1:0]      dec_ext_sel;

    // ---------------- hazard / redirect ----------------
    logic            rs1_hit;
    logic            rs2_hit;
    logic            load_use;
    logic            redirect_c;
    logic            id_live;

    // ---------------- EX stage registers ----------------
    logic            ex_valid_d,   ex_valid_q;
    logic [2:0]      ex_alu_op_d,  ex_alu_op_q;
    logic [1:0]      ex_ext_sel_d, ex_ext_sel_q;
    logic [1:0]      ex_jmp_f_d,   ex_jmp_f_q;
    logic            ex_wpc_d,     ex_wpc_q;
    logic            ex_wmem_d,    ex_wmem_q;
    logic            ex_rmem_d,    ex_rmem_q;
    logic            ex_wreg_d,    ex_wreg_q;
    logic [RA_W-1:0] ex_rd_d,      ex_rd_q;

    // ---------------- MEM stage registers ----------------
    logic            mem_valid_d,  mem_valid_q;
    logic            mem_wmem_d,   mem_wmem_q;
    logic            mem_rmem_d,   mem_rmem_q;
    logic            mem_wreg_d,   mem_wreg_q;
    logic [RA_W-1:0] mem_rd_d,     mem_rd_q;

    // ---------------- WB stage registers ----------------
    logic            wb_valid_d,   wb_valid_q;
    logic            wb_wreg_d,    wb_wreg_q;
    logic [RA_W-1:0] wb_rd_d,      wb_rd_q;

    // Decode the instruction sitting in IF/ID; op==01 falls through every enable term as a NOP.
    always_comb begin
        dec_wmem    = (id_op == 2'b10) && (id_inst == 2'b00) && !id_immin;
        dec_rmem    = (id_op == 2'b10) && (id_inst == 2'b01) && !id_immin;
        dec_wreg    = (id_op == 2'b11) || ((id_op == 2'b10) && (id_inst != 2'b11));
        dec_wpc     = (id_op == 2'b00) && id_immin;
        dec_jmp_f   = id_inst;
        dec_alu_op  = (id_op == 2'b11) ? {id_inst, id_immin} : 3'b000;
        dec_ext_sel = 2'b00;
        case (id_op)
            2'b00:   dec_ext_sel = 2'b10;
            2'b01:   dec_ext_sel = 2'b11;
            2'b10:   dec_ext_sel = 2'b01;
            default: dec_ext_sel = 2'b00;
        endcase
    end

    // Load-use detection against the load in EX, then branch redirect which takes priority over the stall.
    always_comb begin
        // Both sources compared whatever the opcode; register 0 is exempt unless ZERO_REG_HAZ is set.
        rs1_hit    = (ex_rd_q == id_rs1) && ((ZERO_REG_HAZ != 0) || (id_rs1 != '0));
        rs2_hit    = (ex_rd_q == id_rs2) && ((ZERO_REG_HAZ != 0) || (id_rs2 != '0));
        load_use   = id_valid && ex_valid_q && ex_rmem_q && (rs1_hit || rs2_hit);
        redirect_c = ex_valid_q && ex_wpc_q && ex_cond_true;
        // The ID instruction enters EX only when neither a redirect kills it nor a stall holds it back.
        id_live    = id_valid && !redirect_c && !load_use;
    end

    // Next-state for the stage registers; every enable is qualified by the valid of the slot it came from.
    always_comb begin
        ex_valid_d   = id_live;
        ex_alu_op_d  = id_live ? dec_alu_op  : 3'b000;
        ex_ext_sel_d = id_live ? dec_ext_sel : 2'b00;
        ex_jmp_f_d   = id_live ? dec_jmp_f   : 2'b00;
        ex_wpc_d     = id_live && dec_wpc;
        ex_wmem_d    = id_live && dec_wmem;
        ex_rmem_d    = id_live && dec_rmem;
        ex_wreg_d    = id_live && dec_wreg;
        ex_rd_d      = id_live ? id_rd : '0;

        // MEM and WB always advance; a stall only holds IF/ID.
        mem_valid_d  = ex_valid_q;
        mem_wmem_d   = ex_valid_q && ex_wmem_q;
        mem_rmem_d   = ex_valid_q && ex_rmem_q;
        mem_wreg_d   = ex_valid_q && ex_wreg_q;
        mem_rd_d     = ex_rd_q;

        wb_valid_d   = mem_valid_q;
        wb_wreg_d    = mem_valid_q && mem_wreg_q;
        wb_rd_d      = mem_rd_q;
    end

    // Stage registers; synchronous reset drops every in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_alu_op_q  <= 3'b000;
            ex_ext_sel_q <= 2'b00;
            ex_jmp_f_q   <= 2'b00;
            ex_wpc_q     <= 1'b0;
            ex_wmem_q    <= 1'b0;
            ex_rmem_q    <= 1'b0;
            ex_wreg_q    <= 1'b0;
            ex_rd_q      <= '0;
            mem_valid_q  <= 1'b0;
            mem_wmem_q   <= 1'b0;
            mem_rmem_q   <= 1'b0;
            mem_wreg_q   <= 1'b0;
            mem_rd_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_wreg_q    <= 1'b0;
            wb_rd_q      <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_alu_op_q  <= ex_alu_op_d;
            ex_ext_sel_q <= ex_ext_sel_d;
            ex_jmp_f_q   <= ex_jmp_f_d;
            ex_wpc_q     <= ex_wpc_d;
            ex_wmem_q    <= ex_wmem_d;
            ex_rmem_q    <= ex_rmem_d;
            ex_wreg_q    <= ex_wreg_d;
            ex_rd_q      <= ex_rd_d;
            mem_valid_q  <= mem_valid_d;
            mem_wmem_q   <= mem_wmem_d;
            mem_rmem_q   <= mem_rmem_d;
            mem_wreg_q   <= mem_wreg_d;
            mem_rd_q     <= mem_rd_d;
            wb_valid_q   <= wb_valid_d;
            wb_wreg_q    <= wb_wreg_d;
            wb_rd_q      <= wb_rd_d;
        end
    end

    assign stall      = load_use && !redirect_c;
    assign flush      = redirect_c;
    assign redirect   = redirect_c;
    assign ex_valid   = ex_valid_q;
    assign ex_alu_op  = ex_alu_op_q;
    assign ex_ext_sel = ex_ext_sel_q;
    assign ex_jmp_f   = ex_jmp_f_q;
    assign ex_wpc     = ex_wpc_q;
    assign mem_valid  = mem_valid_q;
    assign mem_wmem   = mem_wmem_q;
    assign mem_rmem   = mem_rmem_q;
    assign wb_valid   = wb_valid_q;
    assign wb_wreg    = wb_wreg_q;
    assign wb_rd      = wb_rd_q;

`ifdef CU_PERF_CNT_EN
    logic [15:0] stall_cnt_d, stall_cnt_q;
    logic [15:0] flush_cnt_d, flush_cnt_q;

    // Saturating event counters; they stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    // Counter registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed scenarios then random traffic against an instruction-level pipeline model.
// Two instances share inputs: dut (register 0 exempt) and dut_z (register 0 compares normally).
// The bench plays the IF/ID register: it holds the ID instruction whenever the model predicts a stall.
module tb_pipelined_control_unit;

    typedef struct {
        bit       v;
        bit [1:0] op;
        bit [1:0] inst;
        bit       immin;
        bit [3:0] rd;
        bit [3:0] rs1;
        bit [3:0] rs2;
    } instr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [1:0] id_op = 2'b00;
    logic [1:0] id_inst = 2'b00;
    logic       id_immin = 1'b0;
    logic [3:0] id_rd = 4'd0;
    logic [3:0] id_rs1 = 4'd0;
    logic [3:0] id_rs2 = 4'd0;
    logic       ex_cond_true = 1'b0;

    logic       stall, flush, redirect, ex_valid, ex_wpc, mem_valid, mem_wmem, mem_rmem, wb_valid, wb_wreg;
    logic [2:0] ex_alu_op;
    logic [1:0] ex_ext_sel, ex_jmp_f;
    logic [3:0] wb_rd;
    logic       z_stall, z_flush, z_redirect, z_ex_valid, z_ex_wpc, z_mem_valid, z_mem_wmem, z_mem_rmem;
    logic       z_wb_valid, z_wb_wreg;
    logic [2:0] z_ex_alu_op;
    logic [1:0] z_ex_ext_sel, z_ex_jmp_f;
    logic [3:0] z_wb_rd;
`ifdef CU_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt, z_stall_cnt, z_flush_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    instr_t m_ex, m_mem, m_wb;
    int     m_scnt, m_fcnt;
    bit     last_stall;
    bit     z_sync;

    pipelined_control_unit #(.RA_W(4), .ZERO_REG_HAZ(0)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_inst(id_inst), .id_immin(id_immin),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_cond_true(ex_cond_true),
        .stall(stall), .flush(flush), .redirect(redirect), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_ext_sel(ex_ext_sel), .ex_jmp_f(ex_jmp_f), .ex_wpc(ex_wpc), .mem_valid(mem_valid),
        .mem_wmem(mem_wmem), .mem_rmem(mem_rmem), .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_rd(wb_rd)
`ifdef CU_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    pipelined_control_unit #(.RA_W(4), .ZERO_REG_HAZ(1)) dut_z (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_inst(id_inst), .id_immin(id_immin),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_cond_true(ex_cond_true),
        .stall(z_stall), .flush(z_flush), .redirect(z_redirect), .ex_valid(z_ex_valid), .ex_alu_op(z_ex_alu_op),
        .ex_ext_sel(z_ex_ext_sel), .ex_jmp_f(z_ex_jmp_f), .ex_wpc(z_ex_wpc), .mem_valid(z_mem_valid),
        .mem_wmem(z_mem_wmem), .mem_rmem(z_mem_rmem), .wb_valid(z_wb_valid), .wb_wreg(z_wb_wreg), .wb_rd(z_wb_rd)
`ifdef CU_PERF_CNT_EN
        , .stall_cnt(z_stall_cnt), .flush_cnt(z_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- instruction-level reference rules ----------------
    function automatic bit f_load(instr_t i);
        return i.v && i.op == 2'd2 && i.inst == 2'd1 && !i.immin;
    endfunction
    function automatic bit f_store(instr_t i);
        return i.v && i.op == 2'd2 && i.inst == 2'd0 && !i.immin;
    endfunction
    function automatic bit f_wreg(instr_t i);
        return i.v && (i.op == 2'd3 || (i.op == 2'd2 && i.inst != 2'd3));
    endfunction
    function automatic bit f_branch(instr_t i);
        return i.v && i.op == 2'd0 && i.immin;
    endfunction
    function automatic int f_alu(instr_t i);
        return (i.op == 2'd3) ? (int'(i.inst) * 2 + int'(i.immin)) : 0;
    endfunction
    function automatic int f_ext(instr_t i);
        case (i.op)
            2'd0:    return 2;
            2'd1:    return 3;
            2'd2:    return 1;
            default: return 0;
        endcase
    endfunction
    function automatic bit f_hit(bit [3:0] rd, bit [3:0] rs, bit zh);
        return rd == rs && (zh || rs != 4'd0);
    endfunction
    function automatic bit f_lu(instr_t ex, instr_t id, bit zh);
        return id.v && f_load(ex) && (f_hit(ex.rd, id.rs1, zh) || f_hit(ex.rd, id.rs2, zh));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input bit v, input bit [1:0] op, input bit [1:0] inst, input bit immin,
                          input bit [3:0] rd, input bit [3:0] rs1, input bit [3:0] rs2);
        id_valid = v; id_op = op; id_inst = inst; id_immin = immin;
        id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    endtask

    // One clock: compare everything against the model at negedge, then advance model over the posedge.
    task automatic cycle();
        instr_t cur, empty;
        bit lu0, lu1, rdr, stall_m;
        empty = '{default: 0};
        @(negedge clk);
        cur.v = id_valid; cur.op = id_op; cur.inst = id_inst; cur.immin = id_immin;
        cur.rd = id_rd; cur.rs1 = id_rs1; cur.rs2 = id_rs2;
        lu0 = f_lu(m_ex, cur, 1'b0);
        lu1 = f_lu(m_ex, cur, 1'b1);
        rdr = f_branch(m_ex) && ex_cond_true;
        stall_m = lu0 && !rdr;
        chk("stall", stall, stall_m);
        chk("flush", flush, rdr);
        chk("redirect", redirect, rdr);
        if (z_sync) chk("stall_zreg", z_stall, lu1 && !rdr);
        chk("ex_valid", ex_valid, m_ex.v);
        chk("ex_wpc", ex_wpc, f_branch(m_ex));
        if (m_ex.v) begin
            chk("ex_alu_op", ex_alu_op, f_alu(m_ex));
            chk("ex_ext_sel", ex_ext_sel, f_ext(m_ex));
            chk("ex_jmp_f", ex_jmp_f, m_ex.inst);
        end
        chk("mem_valid", mem_valid, m_mem.v);
        chk("mem_wmem", mem_wmem, f_store(m_mem));
        chk("mem_rmem", mem_rmem, f_load(m_mem));
        chk("wb_valid", wb_valid, m_wb.v);
        chk("wb_wreg", wb_wreg, f_wreg(m_wb));
        if (f_wreg(m_wb)) chk("wb_rd", wb_rd, m_wb.rd);
`ifdef CU_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_scnt);
        chk("flush_cnt", flush_cnt, m_fcnt);
`endif
        @(posedge clk);
        #1;
        if (rst) begin
            m_ex = empty; m_mem = empty; m_wb = empty;
            m_scnt = 0; m_fcnt = 0;
            last_stall = 1'b0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (rdr || lu0) ? empty : cur;
            if (stall_m && m_scnt < 65535) m_scnt++;
            if (rdr && m_fcnt < 65535) m_fcnt++;
            last_stall = stall_m;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ex_cond_true = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        cycle();
        rst = 1'b0;
        z_sync = 1'b1;
    endtask

    initial begin
        m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0};
        m_scnt = 0; m_fcnt = 0; last_stall = 1'b0; z_sync = 1'b1;

        // power-up reset, then the reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_wreg", wb_wreg, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_alu_op", ex_alu_op, 0);
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);

        // ALU pass-through
        set_id(1, 2'd3, 2'd2, 1, 4'd5, 4'd1, 4'd2);
        #1;
        chk("alu_stall", stall, 0);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0);
        chk("alu_ex_valid", ex_valid, 1);
        chk("alu_ex_alu_op", ex_alu_op, 3'b101);
        chk("alu_ex_ext_sel", ex_ext_sel, 2'b00);
        cycle();
        cycle();
        chk("alu_wb_wreg", wb_wreg, 1);
        chk("alu_wb_rd", wb_rd, 5);

        // load-use: one stall cycle, bubble, dependent follows
        do_reset();
        set_id(1, 2'd2, 2'd1, 0, 4'd3, 4'd1, 4'd2);
        cycle();
        set_id(1, 2'd3, 2'd0, 0, 4'd7, 4'd3, 4'd4);
        #1;
        chk("lu_stall", stall, 1);
        cycle();
        #1;
        chk("lu_bubble", ex_valid, 0);
        chk("lu_stall_once", stall, 0);
        chk("lu_mem_rmem", mem_rmem, 1);
        cycle();
        chk("lu_dep_in_ex", ex_valid, 1);
        set_id(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // zero-register exemption, both parameter settings
        do_reset();
        set_id(1, 2'd2, 2'd1, 0, 4'd0, 4'd1, 4'd1);
        cycle();
        set_id(1, 2'd3, 2'd0, 0, 4'd6, 4'd1, 4'd0);
        #1;
        chk("zero_exempt", stall, 0);
        chk("zero_compared", z_stall, 1);
        cycle();
        z_sync = 1'b0;
        do_reset();

        // taken branch flushes the follower
        set_id(1, 2'd0, 2'd2, 1, 4'd0, 4'd1, 4'd2);
        cycle();
        set_id(1, 2'd3, 2'd0, 0, 4'd8, 4'd9, 4'd10);
        ex_cond_true = 1'b1;
        #1;
        chk("br_redirect", redirect, 1);
        chk("br_flush", flush, 1);
        cycle();
        set_id(0, 0, 0, 0, 0, 0, 0);
        ex_cond_true = 1'b0;
        chk("br_bubble", ex_valid, 0);
        chk("br_advances", mem_valid, 1);
        cycle();
        chk("br_follower_gone", mem_valid, 0);

        // not-taken branch
        set_id(1, 2'd0, 2'd2, 1, 4'd0, 4'd1, 4'd2);
        cycle();
        set_id(1, 2'd3, 2'd0, 0, 4'd8, 4'd9, 4'd10);
        #1;
        chk("nt_redirect", redirect, 0);
        chk("nt_flush", flush, 0);
        cycle();
        chk("nt_follower", ex_valid, 1);
        set_id(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // taken branch while ID names the branch's register: flush wins, no stall
        set_id(1, 2'd0, 2'd1, 1, 4'd3, 4'd1, 4'd2);
        cycle();
        set_id(1, 2'd3, 2'd0, 0, 4'd4, 4'd3, 4'd3);
        ex_cond_true = 1'b1;
        #1;
        chk("rvs_flush", flush, 1);
        chk("rvs_stall", stall, 0);
        cycle();
        ex_cond_true = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        chk("rvs_discard", ex_valid, 0);
        cycle();

        // reset while stalled with every stage full
        do_reset();
        set_id(1, 2'd3, 2'd0, 0, 4'd1, 4'd1, 4'd1);
        cycle();
        set_id(1, 2'd3, 2'd0, 1, 4'd2, 4'd1, 4'd1);
        cycle();
        set_id(1, 2'd2, 2'd1, 0, 4'd3, 4'd1, 4'd2);
        cycle();
        set_id(1, 2'd3, 2'd0, 0, 4'd4, 4'd3, 4'd3);
        #1;
        chk("mf_stall", stall, 1);
        chk("mf_wb_valid", wb_valid, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("mf_ex_valid", ex_valid, 0);
        chk("mf_mem_valid", mem_valid, 0);
        chk("mf_mem_rmem", mem_rmem, 0);
        chk("mf_wb_valid0", wb_valid, 0);
        chk("mf_wb_wreg", wb_wreg, 0);
        chk("mf_stall0", stall, 0);
        chk("mf_redirect", redirect, 0);
        cycle();

        // random traffic; registers 1..4 keep both instances in lock-step
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (!last_stall) begin
                set_id(($urandom % 4) != 0, 2'($urandom), 2'($urandom), 1'($urandom),
                       4'($urandom_range(1, 4)), 4'($urandom_range(1, 4)), 4'($urandom_range(1, 4)));
            end
            ex_cond_true = 1'($urandom);
            rst = (($urandom % 64) == 0);
            cycle();
        end
        rst = 1'b0;

`ifdef CU_PERF_CNT_EN
        // drive the stall counter into saturation, then clear it
        do_reset();
        set_id(1, 2'd2, 2'd1, 0, 4'd1, 4'd1, 4'd1);
        for (int i = 0; i < 131090; i++) cycle();
        chk("stall_cnt_sat", stall_cnt, 16'hFFFF);
        do_reset();
        chk("stall_cnt_clr", stall_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
